uart_frame_ctrl: RTL
====================

# uart_frame_ctrl

Frame-level controller downstream of the serial byte receiver. It turns the receiver's byte/valid stream into validated register-write bursts. It detects each new received byte, parses a fixed frame format (header, address, length, payload, checksum), and buffers the payload. Writes are released to the register file only after the checksum passes. It runs in the 40 kHz receiver clock domain.

## Interface
- `HDR`, 8'hA5: frame start byte.
- `ADDR_W`, 4: register-file address width.
- `MAX_LEN`, 8: maximum payload bytes per frame (1..MAX_LEN legal).
- `TIMEOUT_CYC`, 1200: inter-byte timeout, in clock cycles.

- `clk_40k`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `rx_data`, in, 8: received byte; stable while `rx_vld` is high.
- `rx_vld`, in, 1: receiver valid level; high ≥1 cycle per byte, low between bytes.
- `wr_en`, out, 1: register-file write strobe.
- `wr_addr`, out, ADDR_W: write address.
- `wr_data`, out, 8: write data.
- `frame_done`, out, 1: one-cycle pulse when a frame commits.
- `frame_err`, out, 1: one-cycle pulse when a frame is discarded.
- `err_code`, out, 2: last error (0 none, 1 BAD_LEN, 2 BAD_SUM, 3 TIMEOUT); held until the next error.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Byte accept: `rx_vld` is registered. A byte is accepted on the cycle where `rx_vld`=1 and the registered copy is 0. Each high level yields exactly one accept.
- States: IDLE, ADDR, LEN, DATA, CSUM, COMMIT.
- IDLE: an accepted byte equal to `HDR` moves to ADDR. Any other byte is ignored, with no error.
- ADDR: base address = `byte[ADDR_W-1:0]` (upper bits ignored). Running sum = byte. Next state LEN.
- LEN:
  - byte = 0 or byte > `MAX_LEN`: `frame_err`, `err_code`=1, go to IDLE.
  - Otherwise store len, sum += byte, idx = 0, go to DATA.
- DATA: `buf[idx]` = byte, sum += byte, idx++. The byte with idx = len-1 moves to CSUM. A `HDR` value inside the payload is treated as plain data; there is no resync.
- CSUM:
  - byte == sum[7:0]: go to COMMIT.
  - Otherwise: `frame_err`, `err_code`=2, go to IDLE. Nothing is written.
- COMMIT:
  - One write per cycle for i = 0..len-1: `wr_addr` = (base+i) mod 2^ADDR_W, `wr_data` = `buf[i]`.
  - `frame_done` pulses in the same cycle as the last write. The next state is IDLE.
  - Accept edges that arrive during COMMIT are dropped.
- Checksum: 8-bit sum of addr, len and all payload bytes, wrapping mod 256.
- Timeout:
  - The counter runs in ADDR/LEN/DATA/CSUM and clears on every accept and on entry to IDLE.
  - When it reaches `TIMEOUT_CYC`-1: `frame_err`, `err_code`=3, go to IDLE.
  - If an accept and the timeout fall in the same cycle, the accept wins.
- Error pulse and return to IDLE occur in the cycle after the offending accept or timeout.

## Timing
- Reset values:
  - state IDLE, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `frame_err`=0, `err_code`=0, `busy`=0.
  - Counters and sum are 0. Payload buffer contents are don't-care.
- Reset asserted mid-frame or mid-COMMIT aborts immediately. No further writes, no `frame_err`.
- Latency:
  - The first `wr_en` occurs 1 cycle after the checksum accept.
  - A burst spans len consecutive cycles.
  - `frame_done` coincides with the final `wr_en`.
- `wr_addr`/`wr_data` are valid only while `wr_en`=1. They hold their last values otherwise.
- All outputs are registered.

## Structure
- Package `uart_frame_pkg`: state enum, err_code constants (`ERR_NONE`, `ERR_LEN`, `ERR_SUM`, `ERR_TMO`), default `HDR`.
- Sub-module `uart_frame_buf`: MAX_LEN×8 payload buffer with write index and independent read index. Writes occur in DATA, reads occur in COMMIT.
- Edge detection, the FSM, checksum and timeout live in the top level.

## Test plan
- Noise then frame: bytes 3C, A5 03 02 11 22 38 → writes [3]=11, [4]=22 on consecutive cycles; `frame_done` with the second write; `err_code`=0.
- Address wrap: A5 0F 02 AA BB 76 → writes [F]=AA, then [0]=BB.
- Bad checksum: A5 01 01 55 00 → `frame_err`, `err_code`=2, no `wr_en`. A following valid frame commits normally.
- Bad length: A5 00 09 → `frame_err`, `err_code`=1 after the third byte. The FSM is in IDLE, so following bytes are ignored until the next A5.
- Timeout: A5 02, then silence for 1200 cycles → `frame_err`, `err_code`=3, `busy` falls. An accept on the cycle the timeout would fire proceeds instead.
- Reset mid-frame: assert `rst_n`=0 during DATA → all outputs 0 and IDLE. No writes and no error after release.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller: FSM state
// encoding, error codes and the default frame header byte.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_COMMIT
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Index width for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: sequential write index filled during DATA,
// independent read index drained during COMMIT.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned IDX_W   = idx_w(MAX_LEN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [7:0]       i_wr_data,
    input  logic             i_rd_adv,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic [IDX_W-1:0] o_rd_idx,
    output logic [7:0]       o_rd_data
);

    logic [7:0]       r_mem [MAX_LEN];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;

    // Contents need no reset; the indices alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else if (i_clr) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else begin
            if (i_wr) begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
            if (i_rd_adv) begin
                r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
        end
    end

    assign o_wr_idx  = r_wr_idx;
    assign o_rd_idx  = r_rd_idx;
    assign o_rd_data = r_mem[r_rd_idx];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller: turns the receiver byte stream into checksum-validated
// register-write bursts (HDR, addr, len, payload, checksum).
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HDR         = HDR_DEFAULT,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC = 1200
) (
    input  logic              clk_40k,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_vld,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int unsigned IDX_W = idx_w(MAX_LEN);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned TMO_W = idx_w(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic              r_vld_d;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic              r_busy;

    state_t            w_nxt_state;
    logic [TMO_W-1:0]  w_nxt_tmo;
    logic [7:0]        w_nxt_sum;
    logic [ADDR_W-1:0] w_nxt_base;
    logic [LEN_W-1:0]  w_nxt_len;
    logic              w_nxt_wr_en;
    logic [ADDR_W-1:0] w_nxt_wr_addr;
    logic [7:0]        w_nxt_wr_data;
    logic              w_nxt_done;
    logic              w_nxt_err;
    logic [1:0]        w_nxt_err_code;

    logic              w_accept;
    logic              w_timed;
    logic              w_tmo;
    logic              w_len_bad;
    logic              w_data_last;
    logic              w_rd_last;
    logic              w_emit;
    logic              w_buf_clr;
    logic              w_buf_wr;
    logic              w_rd_adv;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [7:0]        w_rd_data;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_buf (
        .i_clk     (clk_40k),
        .i_rst_n   (rst_n),
        .i_clr     (w_buf_clr),
        .i_wr      (w_buf_wr),
        .i_wr_data (rx_data),
        .i_rd_adv  (w_rd_adv),
        .o_wr_idx  (w_wr_idx),
        .o_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_accept    = rx_vld && !r_vld_d;
    assign w_timed     = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                         (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_tmo       = (r_tmo_cnt == TMO_LAST);
    assign w_len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
    assign w_data_last = (LEN_W'(w_wr_idx) == r_len - LEN_W'(1));
    assign w_rd_last   = (LEN_W'(w_rd_idx) == r_len - LEN_W'(1));

    always_ff @(posedge clk_40k or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_sum      = r_sum;
        w_nxt_base     = r_base;
        w_nxt_len      = r_len;
        w_nxt_wr_en    = 1'b0;
        w_nxt_wr_addr  = r_wr_addr;
        w_nxt_wr_data  = r_wr_data;
        w_nxt_done     = 1'b0;
        w_nxt_err      = 1'b0;
        w_nxt_err_code = r_err_code;
        w_nxt_tmo      = '0;
        w_buf_clr      = 1'b0;
        w_buf_wr       = 1'b0;
        w_rd_adv       = 1'b0;
        w_emit         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && rx_data == HDR) begin
                    w_nxt_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_nxt_base  = rx_data[ADDR_W-1:0];
                    w_nxt_sum   = rx_data;
                    w_nxt_state = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    if (w_len_bad) begin
                        w_nxt_err      = 1'b1;
                        w_nxt_err_code = ERR_LEN;
                        w_nxt_state    = ST_IDLE;
                    end else begin
                        w_nxt_len   = rx_data[LEN_W-1:0];
                        w_nxt_sum   = r_sum + rx_data;
                        w_buf_clr   = 1'b1;
                        w_nxt_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_buf_wr  = 1'b1;
                    w_nxt_sum = r_sum + rx_data;
                    if (w_data_last) begin
                        w_nxt_state = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    if (rx_data == r_sum) begin
                        w_emit      = 1'b1;
                        w_nxt_state = ST_COMMIT;
                    end else begin
                        w_nxt_err      = 1'b1;
                        w_nxt_err_code = ERR_SUM;
                        w_nxt_state    = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                w_emit = 1'b1;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // The first write is issued from the checksum cycle itself, so a
        // burst of len writes ends with the state already back in IDLE.
        if (w_emit) begin
            w_nxt_wr_en   = 1'b1;
            w_nxt_wr_addr = r_base + ADDR_W'(w_rd_idx);
            w_nxt_wr_data = w_rd_data;
            w_rd_adv      = 1'b1;
            if (w_rd_last) begin
                w_nxt_done  = 1'b1;
                w_nxt_state = ST_IDLE;
            end
        end

        if (w_timed && !w_accept) begin
            if (w_tmo) begin
                w_nxt_err      = 1'b1;
                w_nxt_err_code = ERR_TMO;
                w_nxt_state    = ST_IDLE;
            end else begin
                w_nxt_tmo = r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_40k or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_d    <= 1'b0;
            r_tmo_cnt  <= '0;
            r_sum      <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b0;
        end else begin
            r_vld_d    <= rx_vld;
            r_tmo_cnt  <= w_nxt_tmo;
            r_sum      <= w_nxt_sum;
            r_base     <= w_nxt_base;
            r_len      <= w_nxt_len;
            r_wr_en    <= w_nxt_wr_en;
            r_wr_addr  <= w_nxt_wr_addr;
            r_wr_data  <= w_nxt_wr_data;
            r_done     <= w_nxt_done;
            r_err      <= w_nxt_err;
            r_err_code <= w_nxt_err_code;
            r_busy     <= (w_nxt_state != ST_IDLE);
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign err_code   = r_err_code;
    assign busy       = r_busy;

endmodule
